// File: rtl/score_display_scan.sv
// score_display_scan: 3-digit multiplexed 7-segment score display with a
// sequential binary-to-BCD converter and fixed finish/game-over messages.
module score_display_scan #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2,
    parameter int VALUE_W  = 11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               disp_on,
    input  logic [1:0]         mode,
    input  logic [VALUE_W-1:0] score,
    output logic [6:0]         seg,
    output logic [2:0]         an,
    output logic               dp,
    output logic               bcd_busy
);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] ITER_LAST  = IW'(VALUE_W - 1);
    localparam logic [VALUE_W-1:0] MAX_SCORE = VALUE_W'(999);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_t;

    conv_t              state;
    logic [VALUE_W-1:0] last_score;
    logic [VALUE_W-1:0] cur_score;
    logic [VALUE_W-1:0] bin;
    logic [11:0]        bcd;
    logic [11:0]        bcd_adj;
    logic [11:0]        pend_bcd;
    logic [11:0]        shown;
    logic [IW-1:0]      iter;

    logic          disp_q;
    logic [1:0]    mode_q;
    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    idx;
    logic          phase;
    logic          scan_tick;
    logic          blink_tick;

    logic [3:0] digit;
    logic [3:0] code;
    logic       lead;
    logic       lit;
    logic [6:0] glyph;

    assign scan_tick  = (scan_cnt == SCAN_LAST);
    assign blink_tick = (blink_cnt == BLINK_LAST);
    assign bcd_busy   = (state == SHIFT);
    assign dp         = 1'b1;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Input is clamped before shifting, so the 12-bit BCD field never overflows.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_score <= '0;
            cur_score  <= '0;
            bin        <= '0;
            bcd        <= '0;
            pend_bcd   <= '0;
            iter       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (score != last_score) begin
                        cur_score <= score;
                        bin       <= (score > MAX_SCORE) ? MAX_SCORE : score;
                        bcd       <= '0;
                        iter      <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
                    iter       <= iter + IW'(1);
                    if (iter == ITER_LAST)
                        state <= DONE;
                end
                DONE: begin
                    pend_bcd   <= bcd;
                    last_score <= cur_score;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_q    <= 1'b0;
            mode_q    <= 2'd0;
            scan_cnt  <= '0;
            blink_cnt <= '0;
            idx       <= 2'd0;
            shown     <= '0;
            phase     <= 1'b1;
        end else begin
            disp_q    <= disp_on;
            mode_q    <= mode;
            scan_cnt  <= scan_tick ? '0 : scan_cnt + SW'(1);
            blink_cnt <= blink_tick ? '0 : blink_cnt + BW'(1);
            if (scan_tick) begin
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                if (idx == 2'd2)
                    shown <= pend_bcd;
            end
            if (mode == 2'd3 && mode_q != 2'd3)
                phase <= 1'b1;
            else if (blink_tick)
                phase <= ~phase;
        end
    end

    // Message codes: C,P,O = A,B,C and G,V,r = D,E,F, leftmost at idx 2.
    always_comb begin
        digit = shown[3:0];
        lead  = 1'b0;
        unique case (idx)
            2'd1: begin
                digit = shown[7:4];
                lead  = (shown[11:4] == 8'd0);
            end
            2'd2: begin
                digit = shown[11:8];
                lead  = (shown[11:8] == 4'd0);
            end
            default: digit = shown[3:0];
        endcase
        code = digit;
        unique case (mode_q)
            2'd2:    code = 4'hC - {2'b00, idx};
            2'd3:    code = 4'hF - {2'b00, idx};
            default: code = digit;
        endcase
    end

    always_comb begin
        glyph = 7'h7F;
        unique case (code)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h46;
            4'hB: glyph = 7'h0C;
            4'hC: glyph = 7'h40;
            4'hD: glyph = 7'h42;
            4'hE: glyph = 7'h41;
            4'hF: glyph = 7'h2F;
            default: glyph = 7'h7F;
        endcase
    end

    always_comb begin
        lit = disp_q && !scan_tick && (mode_q != 2'd0)
            && !(mode_q == 2'd3 && !phase)
            && !(mode_q == 2'd1 && lead);
        an  = lit ? ~(3'b001 << idx) : 3'b111;
        seg = lit ? glyph : 7'h7F;
    end

endmodule

// File: tb/tb_score_display_scan.sv
// tb_score_display_scan: cycle-accurate reference model of the display,
// driven by directed and random score/mode/power sequences.
module tb_score_display_scan;
    localparam int SD = 10;
    localparam int BD = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        disp_on;
    logic [1:0]  mode;
    logic [10:0] score;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        dp;
    logic        bcd_busy;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    int k;
    int m_start;
    int m_val;
    int m_last;
    int m_pend;
    int m_shown;
    bit m_phase;
    bit m_disp;
    int m_mode;

    score_display_scan #(
        .CLK_HZ(1000),
        .SCAN_HZ(100),
        .BLINK_HZ(50),
        .VALUE_W(11)
    ) dut (
        .clock(clock),
        .reset(reset),
        .disp_on(disp_on),
        .mode(mode),
        .score(score),
        .seg(seg),
        .an(an),
        .dp(dp),
        .bcd_busy(bcd_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] segs(input string s);
        logic [6:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++)
            v[int'(s[i]) - 97] = 1'b1;
        return ~v;
    endfunction

    function automatic logic [6:0] dseg(input int d);
        case (d)
            0: return segs("abcdef");
            1: return segs("bc");
            2: return segs("abdeg");
            3: return segs("abcdg");
            4: return segs("bcfg");
            5: return segs("acdfg");
            6: return segs("acdefg");
            7: return segs("abc");
            8: return segs("abcdefg");
            default: return segs("abcdfg");
        endcase
    endfunction

    task automatic expect_out(output logic [2:0] ea, output logic [6:0] es);
        int  i;
        bit  vis;
        logic [6:0] g;
        ea = 3'b111;
        es = 7'h7F;
        if (!m_disp || m_mode == 0 || k % SD == SD - 1)
            return;
        i = (k / SD) % 3;
        vis = 1'b1;
        g = 7'h7F;
        if (m_mode == 1) begin
            if (i == 0) g = dseg(m_shown % 10);
            if (i == 1) begin g = dseg((m_shown / 10) % 10); vis = m_shown >= 10; end
            if (i == 2) begin g = dseg(m_shown / 100); vis = m_shown >= 100; end
        end else if (m_mode == 2) begin
            g = (i == 2) ? segs("adef") : (i == 1) ? segs("abefg") : segs("abcdef");
        end else begin
            g = (i == 2) ? segs("acdef") : (i == 1) ? segs("bcdef") : segs("eg");
            vis = m_phase;
        end
        if (vis) begin
            ea = ~(3'b001 << i);
            es = g;
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s k=%0d: got %h want %h", tag, k, got, want);
        end
    endtask

    task automatic tick();
        logic r, d;
        int md, sc;
        logic [2:0] ea;
        logic [6:0] es;
        bit eb;
        r = reset;
        d = disp_on;
        md = int'(mode);
        sc = int'(score);
        @(posedge clock);
        if (r) begin
            k = 0; m_start = -1; m_last = 0; m_pend = 0; m_shown = 0;
            m_phase = 1'b1; m_disp = 1'b0; m_mode = 0;
        end else begin
            if (k % (3 * SD) == 3 * SD - 1) m_shown = m_pend;
            if (m_start >= 0 && k == m_start + 12) begin
                m_pend = (m_val > 999) ? 999 : m_val;
                m_last = m_val;
                m_start = -1;
            end else if (m_start < 0 && sc != m_last) begin
                m_start = k;
                m_val = sc;
            end
            if (md == 3 && m_mode != 3) m_phase = 1'b1;
            else if (k % BD == BD - 1) m_phase = !m_phase;
            m_disp = d;
            m_mode = md;
            k++;
        end
        #1;
        expect_out(ea, es);
        eb = (m_start >= 0) && (k >= m_start + 1) && (k <= m_start + 11);
        if (bcd_busy) busy_cnt++;
        chk("an", {9'd0, an}, {9'd0, ea});
        chk("seg", {5'd0, seg}, {5'd0, es});
        chk("busy", {11'd0, bcd_busy}, {11'd0, eb});
        chk("dp", {11'd0, dp}, 12'd1);
    endtask

    initial begin
        reset = 1'b1; disp_on = 1'b0; mode = 2'd0; score = 11'd0;
        repeat (3) tick();
        reset = 1'b0; disp_on = 1'b1; mode = 2'd1;
        repeat (60) tick();

        score = 11'd427; busy_cnt = 0;
        repeat (14) tick();
        chk("busy_len", 12'(busy_cnt), 12'd11);
        repeat (60) tick();

        score = 11'd600;
        repeat (40) tick();
        mode = 2'd2;
        repeat (40) tick();
        mode = 2'd3;
        repeat (60) tick();

        mode = 2'd1; score = 11'd1500;
        repeat (70) tick();
        score = 11'd5;
        repeat (70) tick();

        score = 11'd120;
        repeat (65) tick();
        score = 11'd121;
        repeat (60) tick();
        score = 11'd300;
        repeat (4) tick();
        score = 11'd121;
        repeat (90) tick();

        score = 11'd42;
        repeat (5) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (75) tick();
        disp_on = 1'b0;
        tick();
        chk("off_an", {9'd0, an}, 12'h007);
        disp_on = 1'b1;

        repeat (50) begin
            score = ($urandom_range(0, 9) == 0) ? 11'($urandom)
                                                : 11'($urandom_range(0, 1100));
            mode = 2'($urandom_range(0, 3));
            disp_on = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(1, 40)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
